// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow and flush.
// Ports: clk, rst (async high), flush (sync clear); write side we/wdata,
// full/almost_full; read side re/rdata, empty/almost_empty; count (0..DEPTH);
// overflow/underflow sticky error flags. FWFT selects registered or
// first-word-fall-through read data.
module sync_fifo_flags #(
    parameter int WIDTH    = 3,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     we,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     re,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic rd_ok;
    logic wr_ok;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // In FWFT mode the head word is presented straight from the array.
    assign rdata = (FWFT != 0) ? mem[rd_ptr_q] : rdata_q;

    // A read on a full FIFO frees the slot the concurrent write needs.
    assign rd_ok = re & ~empty;
    assign wr_ok = we & (~full | rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rdata_d  = rdata_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                rdata_d  = mem[rd_ptr_q];
            end
            count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
            if (we & full & ~rd_ok) begin
                ovf_d = 1'b1;
            end
            if (re & empty) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok & ~flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule
